// File: rtl/timer_pkg.sv
// Shared definitions for the timer scheduler slice.
// Provides the FSM state encoding and default sizing used by timer_sched
// and rr_pick.
package timer_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_PERIOD_W = 4;
  localparam int DEF_IDX_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker (purely combinational).
// Finds the first set bit of req at or after rr_ptr, searching upward
// and wrapping past the top requester.
// Ports:
//   req    : request vector, one bit per requester
//   rr_ptr : index where the search starts (must be < N_REQ)
//   found  : at least one request is set
//   idx    : index of the chosen requester (valid when found=1)
module rr_pick
  import timer_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot_s;
  logic [IDX_W-1:0] off_s;
  logic [IDX_W:0]   sum_s;

  function automatic int wrap_idx(input int v);
    if (v >= N_REQ) begin
      return v - N_REQ;
    end else begin
      return v;
    end
  endfunction

  // Rotate req so that bit 0 of rot_s is requester rr_ptr.
  always_comb begin
    rot_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      rot_s[i] = req[IDX_W'(wrap_idx(int'(rr_ptr) + i))];
    end
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    off_s = {IDX_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = IDX_W'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  // Un-rotate: add the offset back onto rr_ptr modulo N_REQ.
  always_comb begin
    found = |rot_s;
    sum_s = {1'b0, rr_ptr} + {1'b0, off_s};
    if (sum_s >= (IDX_W+1)'(N_REQ)) begin
      idx = IDX_W'(sum_s - (IDX_W+1)'(N_REQ));
    end else begin
      idx = sum_s[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Timer scheduler: shares one period timer among N_REQ requesters.
// A requester is picked round-robin, its period is written to the timer,
// the timer is started, and on the timer's end pulse a one-cycle done is
// returned to that requester. Dropping the request while waiting aborts
// the service and clears the timer.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-low reset
//   req         : level requests, held until done or cancel
//   period_in   : packed periods, requester i at [i*PERIOD_W +: PERIOD_W]
//   gnt, done   : one-hot grant (LOAD..DONE/ABORT) and done pulse
//   busy        : high outside IDLE
//   tmr_period, tmr_we, tmr_start, tmr_clr : timer control
//   tmr_end     : one-cycle end pulse from the timer
// All outputs are registers loaded from the next-state decode, so they
// line up cycle-for-cycle with the state they describe.
module timer_sched
  import timer_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*PERIOD_W-1:0] period_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic                      busy,
  output logic [PERIOD_W-1:0]       tmr_period,
  output logic                      tmr_we,
  output logic                      tmr_start,
  output logic                      tmr_clr,
  input  logic                      tmr_end
);

  state_t                state_r, state_s;
  logic [IDX_W-1:0]      rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0]      sel_idx_r, sel_idx_s;
  logic [PERIOD_W-1:0]   sel_period_r, sel_period_s;
  logic                  pick_found_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic [PERIOD_W-1:0]   pick_period_s;

  logic [N_REQ-1:0]      gnt_r, gnt_s;
  logic [N_REQ-1:0]      done_r, done_s;
  logic                  busy_r, busy_s;
  logic [PERIOD_W-1:0]   tmr_period_r, tmr_period_s;
  logic                  tmr_we_r, tmr_we_s;
  logic                  tmr_start_r, tmr_start_s;
  logic                  tmr_clr_r, tmr_clr_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_REQ - 1)) begin
      next_ptr = {IDX_W{1'b0}};
    end else begin
      next_ptr = i + IDX_W'(1);
    end
  endfunction

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .found  (pick_found_s),
    .idx    (pick_idx_s)
  );

  // Select the period of the requester the picker chose.
  always_comb begin
    pick_period_s = {PERIOD_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx_s == IDX_W'(i)) begin
        pick_period_s = period_in[i*PERIOD_W +: PERIOD_W];
      end else begin
        pick_period_s = pick_period_s;
      end
    end
  end

  // Next-state logic; the selection is only captured in IDLE, so later
  // changes to req or period_in do not disturb the service in flight.
  always_comb begin
    state_s      = state_r;
    rr_ptr_s     = rr_ptr_r;
    sel_idx_s    = sel_idx_r;
    sel_period_s = sel_period_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_s      = ST_LOAD;
          sel_idx_s    = pick_idx_s;
          sel_period_s = pick_period_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A zero period never starts the timer.
        if (sel_period_r == {PERIOD_W{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_START;
        end
      end
      ST_START: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // End wins over a cancel seen in the same cycle.
        if (tmr_end) begin
          state_s = ST_DONE;
        end else if (!req[sel_idx_r]) begin
          state_s = ST_ABORT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s  = ST_IDLE;
        rr_ptr_s = next_ptr(sel_idx_r);
      end
      ST_ABORT: begin
        state_s  = ST_IDLE;
        rr_ptr_s = next_ptr(sel_idx_r);
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, registered below.
  always_comb begin
    busy_s      = (state_s != ST_IDLE);
    tmr_we_s    = (state_s == ST_LOAD);
    tmr_start_s = (state_s == ST_START);
    tmr_clr_s   = (state_s == ST_ABORT);
    if (busy_s) begin
      gnt_s = onehot(sel_idx_s);
    end else begin
      gnt_s = {N_REQ{1'b0}};
    end
    if (state_s == ST_DONE) begin
      done_s = onehot(sel_idx_s);
    end else begin
      done_s = {N_REQ{1'b0}};
    end
    if (state_s == ST_LOAD) begin
      tmr_period_s = sel_period_s;
    end else begin
      tmr_period_s = tmr_period_r;
    end
  end

  // State, selection and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= {IDX_W{1'b0}};
      sel_idx_r    <= {IDX_W{1'b0}};
      sel_period_r <= {PERIOD_W{1'b0}};
      gnt_r        <= {N_REQ{1'b0}};
      done_r       <= {N_REQ{1'b0}};
      busy_r       <= 1'b0;
      tmr_period_r <= {PERIOD_W{1'b0}};
      tmr_we_r     <= 1'b0;
      tmr_start_r  <= 1'b0;
      tmr_clr_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      rr_ptr_r     <= rr_ptr_s;
      sel_idx_r    <= sel_idx_s;
      sel_period_r <= sel_period_s;
      gnt_r        <= gnt_s;
      done_r       <= done_s;
      busy_r       <= busy_s;
      tmr_period_r <= tmr_period_s;
      tmr_we_r     <= tmr_we_s;
      tmr_start_r  <= tmr_start_s;
      tmr_clr_r    <= tmr_clr_s;
    end
  end

  assign gnt        = gnt_r;
  assign done       = done_r;
  assign busy       = busy_r;
  assign tmr_period = tmr_period_r;
  assign tmr_we     = tmr_we_r;
  assign tmr_start  = tmr_start_r;
  assign tmr_clr    = tmr_clr_r;

endmodule

// File: tb/tb_timer_sched.sv
// Scoreboard bench for timer_sched: stimulus pushes expected timer writes,
// done pulses and aborts; a negedge monitor pops and compares them.
module tb_timer_sched;

  localparam int K_WE   = 0;
  localparam int K_DONE = 1;
  localparam int K_CLR  = 2;

  typedef struct {
    int kind;
    int idx;
    int per;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] period_in;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  tmr_period;
  logic        tmr_we;
  logic        tmr_start;
  logic        tmr_clr;
  logic        tmr_end;
  logic        tmr_end_f;
  logic        tmr_end_m;
  logic        tm_auto;
  int          tm_cnt;

  int  checks;
  int  failures;
  int  cyc;
  int  done_seen;
  int  last_done;
  bit  gap_chk;
  ev_t sb_q[$];

  assign tmr_end = tmr_end_f | tmr_end_m;

  timer_sched #(
    .N_REQ    (4),
    .PERIOD_W (4),
    .IDX_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .period_in  (period_in),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .tmr_period (tmr_period),
    .tmr_we     (tmr_we),
    .tmr_start  (tmr_start),
    .tmr_clr    (tmr_clr),
    .tmr_end    (tmr_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] oh(input int i);
    oh = 32'd1 << i;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int i, input int p);
    ev_t e;
    e.kind = k;
    e.idx  = i;
    e.per  = p;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, input int target, input int budget, output int n);
    n = 0;
    while (done_seen < target && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 32'(done_seen >= target), 32'd1);
  endtask

  // Timer model: end pulse tmr_period cycles after the start pulse.
  always @(negedge clk) begin
    tmr_end_m = 1'b0;
    if (!rst || tmr_clr) begin
      tm_cnt = 0;
    end else begin
      if (tm_cnt != 0) begin
        tm_cnt = tm_cnt - 1;
        if (tm_cnt == 0) tmr_end_m = 1'b1;
      end
      if (tmr_start && tm_auto) tm_cnt = int'(tmr_period);
    end
  end

  // Monitor: compares every timer write, done pulse and abort with the queue.
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      cyc = cyc + 1;
      if (tmr_we) begin
        if (gap_chk && last_done >= 0) chk("rr_idle_gap", 32'(cyc - last_done), 32'd2);
        if (sb_q.size() == 0) begin
          chk("sb_extra_we", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("we_kind", 32'(e.kind), 32'(K_WE));
          chk("we_gnt", 32'(gnt), oh(e.idx));
          chk("we_period", 32'(tmr_period), 32'(e.per));
        end
      end
      if (done != 4'b0000) begin
        done_seen = done_seen + 1;
        last_done = cyc;
        if (sb_q.size() == 0) begin
          chk("sb_extra_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_kind", 32'(e.kind), 32'(K_DONE));
          chk("done_bit", 32'(done), oh(e.idx));
          chk("done_gnt", 32'(gnt), oh(e.idx));
        end
      end
      if (tmr_clr) begin
        if (sb_q.size() == 0) begin
          chk("sb_extra_clr", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("clr_kind", 32'(e.kind), 32'(K_CLR));
          chk("clr_gnt", 32'(gnt), oh(e.idx));
          chk("clr_no_done", 32'(done), 32'd0);
        end
      end
    end
  end

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    done_seen = 0;
    last_done = -1;
    gap_chk   = 1'b0;
    tm_auto   = 1'b1;
    tm_cnt    = 0;
    tmr_end_f = 1'b0;
    tmr_end_m = 1'b0;
    rst       = 1'b0;
    req       = 4'b0000;
    period_in = 16'h0000;

    // Reset state.
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmr", 32'({tmr_we, tmr_start, tmr_clr, tmr_period}), 32'd0);
    rst = 1'b1;
    tick();

    // Round-robin fairness with all four requesting: 0,1,2,3,0.
    period_in = {4'd4, 4'd3, 4'd2, 4'd1};
    push(K_WE, 0, 1); push(K_DONE, 0, 0);
    push(K_WE, 1, 2); push(K_DONE, 1, 0);
    push(K_WE, 2, 3); push(K_DONE, 2, 0);
    push(K_WE, 3, 4); push(K_DONE, 3, 0);
    push(K_WE, 0, 1); push(K_DONE, 0, 0);
    gap_chk   = 1'b1;
    last_done = -1;
    req       = 4'b1111;
    wait_done("rr_timeout", done_seen + 5, 200, n);
    req = 4'b0000;
    tick();
    gap_chk = 1'b0;
    chk("rr_busy_fall", 32'(busy), 32'd0);

    // Single request, period 5 (rr_ptr is 1, search wraps to 0).
    period_in = {4'd0, 4'd0, 4'd0, 4'd5};
    push(K_WE, 0, 5); push(K_DONE, 0, 0);
    req = 4'b0001;
    tick();
    chk("single_load_gnt", 32'(gnt), 32'h1);
    chk("single_load_we", 32'(tmr_we), 32'd1);
    chk("single_load_start", 32'(tmr_start), 32'd0);
    chk("single_load_busy", 32'(busy), 32'd1);
    tick();
    chk("single_start", 32'(tmr_start), 32'd1);
    chk("single_start_we", 32'(tmr_we), 32'd0);
    wait_done("single_timeout", done_seen + 1, 50, n);
    chk("single_done_lat", 32'(n), 32'd6);
    req = 4'b0000;
    tick();
    chk("single_busy_fall", 32'(busy), 32'd0);
    chk("single_gnt_fall", 32'(gnt), 32'd0);

    // rr_ptr is now 1: requesters 0 and 1 pending, 1 goes first.
    period_in = {4'd0, 4'd0, 4'd3, 4'd2};
    push(K_WE, 1, 3); push(K_DONE, 1, 0);
    push(K_WE, 0, 2); push(K_DONE, 0, 0);
    req = 4'b0011;
    wait_done("ptr1_timeout", done_seen + 2, 100, n);
    req = 4'b0000;
    tick();

    // Zero period: LOAD then DONE, timer never started.
    period_in = 16'h0000;
    push(K_WE, 2, 0); push(K_DONE, 2, 0);
    req = 4'b0100;
    tick();
    chk("zero_we", 32'(tmr_we), 32'd1);
    tick();
    chk("zero_done", 32'(done), 32'h4);
    chk("zero_no_start", 32'(tmr_start), 32'd0);
    req = 4'b0000;
    tick();
    chk("zero_idle", 32'(busy), 32'd0);

    // Cancel three cycles into WAIT (rr_ptr 3, picks 1).
    period_in = 16'h0090;
    push(K_WE, 1, 9); push(K_CLR, 1, 0);
    req = 4'b0010;
    tick();
    tick();
    tick();
    tick();
    tick();
    req = 4'b0000;
    tick();
    chk("cancel_clr", 32'(tmr_clr), 32'd1);
    chk("cancel_no_done", 32'(done), 32'd0);
    tick();
    chk("cancel_idle", 32'(busy), 32'd0);
    chk("cancel_clr_pulse", 32'(tmr_clr), 32'd0);

    // rr_ptr is 2 after the abort: requesters 1 and 2 pending, 2 wins.
    period_in = {4'd0, 4'd1, 4'd1, 4'd0};
    push(K_WE, 2, 1); push(K_DONE, 2, 0);
    req = 4'b0110;
    wait_done("ptr2_timeout", done_seen + 1, 50, n);
    req = 4'b0000;
    tick();

    // Cancel coincident with tmr_end: end wins (rr_ptr 3, picks 1).
    tm_auto   = 1'b0;
    period_in = 16'h0090;
    push(K_WE, 1, 9); push(K_DONE, 1, 0);
    req = 4'b0010;
    tick();
    tick();
    tick();
    tick();
    req       = 4'b0000;
    tmr_end_f = 1'b1;
    tick();
    tmr_end_f = 1'b0;
    chk("coinc_done", 32'(done), 32'h2);
    chk("coinc_no_clr", 32'(tmr_clr), 32'd0);
    tick();
    chk("coinc_no_clr2", 32'(tmr_clr), 32'd0);
    chk("coinc_idle", 32'(busy), 32'd0);
    tm_auto = 1'b1;

    // Stray tmr_end in IDLE and LOAD; period_in change during WAIT.
    tmr_end_f = 1'b1;
    tick();
    tmr_end_f = 1'b0;
    chk("stray_idle_busy", 32'(busy), 32'd0);
    period_in = {4'd0, 4'd6, 4'd0, 4'd0};
    push(K_WE, 2, 6); push(K_DONE, 2, 0);
    req = 4'b0100;
    tick();
    tmr_end_f = 1'b1;
    tick();
    tmr_end_f = 1'b0;
    chk("stray_load_start", 32'(tmr_start), 32'd1);
    chk("stray_load_done", 32'(done), 32'd0);
    tick();
    period_in = 16'h0F00;
    tick();
    chk("hold_period", 32'(tmr_period), 32'd6);
    wait_done("stray_timeout", done_seen + 1, 50, n);
    req = 4'b0000;
    tick();

    // Async reset mid-WAIT, then wrap to requester 3 from rr_ptr 0.
    period_in = 16'h0009;
    push(K_WE, 0, 9);
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tmr", 32'({tmr_we, tmr_start, tmr_clr, tmr_period, done}), 32'd0);
    req       = 4'b1000;
    period_in = 16'h2000;
    push(K_WE, 3, 2); push(K_DONE, 3, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("arst_first_gnt", 32'(gnt), 32'h8);
    wait_done("arst_timeout", done_seen + 1, 50, n);
    req = 4'b0000;
    tick();
    chk("final_idle", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
